pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined CPU; successor to the plain PC register.
- Holds the fetch PC and issues it to instruction memory with a valid/ready handshake.
- Supports stall, prioritised redirects (trap, jump, branch), buffering of a redirect that arrives while fetch cannot advance, and a halt state.
- Sits between the EX/trap logic (redirect sources) and the IF stage/imem.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VEC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_001C, PC loaded on trap.
- STEP, 4, sequential increment in bytes (power of two, 2 or 4).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  IF stage hold from hazard unit.
- fetch_ready_i  in  1  imem accepts the current pc_o this cycle.
- br_taken_i  in  1  branch resolved taken (one-cycle pulse).
- br_target_i  in  XLEN  branch target.
- jmp_i  in  1  jal/jalr resolved (one-cycle pulse).
- jmp_target_i  in  XLEN  jump target.
- trap_i  in  1  exception/ecall (one-cycle pulse).
- halt_i  in  1  stop fetching (ebreak/end-of-program).
- resume_i  in  1  leave HALT.
- pc_o  out  XLEN  current fetch PC.
- pc_plus_o  out  XLEN  pc_o + STEP, combinational.
- fetch_valid_o  out  1  pc_o is a valid fetch request.
- flush_o  out  1  one-cycle pulse when a redirect is applied; IF/ID must squash.
- misalign_o  out  1  one-cycle pulse when an applied target had nonzero low bits.

Behaviour:
- Reset (async): pc_o=RESET_VEC, fetch_valid_o=0, flush_o=0, misalign_o=0, pending cleared, state=BOOT.
- States:
  - BOOT: one cycle with fetch_valid_o=0, then RUN.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0, pc_o frozen.
- Advance condition: adv = state==RUN && fetch_ready_i && !stall_i.
- Redirect selection, priority trap > jump > branch: trap uses TRAP_VEC, jump uses jmp_target_i, branch uses br_target_i.
- Redirect when adv=1:
  - pc_o <= selected target, with the low log2(STEP) bits forced to 0.
  - flush_o=1 the next cycle.
  - misalign_o=1 the next cycle if the forced bits were nonzero.
- Redirect when adv=0: latch the target into the pending register with valid=1. A later redirect overwrites it only if its priority is greater than or equal to the stored one.
- Pending applied: on the first adv cycle, pc_o <= pending target, flush_o pulses, pending clears.
  - A new redirect in that same cycle wins if its priority is at least the pending one; otherwise the pending target applies and the new one is dropped.
- No redirect and adv=1: pc_o <= pc_o + STEP, wrapping modulo 2^XLEN (carry discarded).
- adv=0 and no redirect: pc_o holds.
- halt_i in RUN: go to HALT next cycle. Any redirect in the same cycle is applied first, so the PC is correct on resume.
- A trap in HALT goes to RUN with pc_o=TRAP_VEC. Otherwise resume_i goes to RUN with pc_o unchanged.
- halt_i and resume_i together: halt_i wins.
- Redirect inputs during BOOT are latched as pending.
- Reset mid-operation: everything returns to reset values immediately; the pending redirect is lost.

Optional Feature:
- Macro: PC_PERF_EN.
- When defined, adds two outputs:
  - fetch_cnt_o [31:0]: increments on every adv cycle.
  - redirect_cnt_o [31:0]: increments on every flush_o pulse.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN_DEF, RESET_VEC_DEF, TRAP_VEC_DEF.
  - State enum pc_state_t (BOOT, RUN, HALT).
  - Redirect priority enum redir_src_t (NONE, BR, JMP, TRAP).
- One natural sub-module: pc_redirect_buf, which holds the pending target/source register and the priority compare.

Test Plan:
- Sequential and reset:
  - Stimulus: rst pulse, ready=1, no redirects.
  - Response: pc_o=0 for BOOT plus the first RUN cycle, then 4, 8, 12.
  - Async check: asserting rst mid-cycle forces pc_o=0 before the next edge.
- Branch vs jump:
  - Stimulus: at pc=0x10, br_taken_i and jmp_i together, targets 0x40 and 0x80.
  - Response: pc_o=0x80 next cycle and flush_o=1 for one cycle.
- Buffered redirect:
  - Stimulus: stall_i=1 for 3 cycles, branch to 0x100 in stall cycle 1, trap in cycle 2.
  - Response: pc_o held; after release pc_o=0x1C with one flush_o pulse; 0x100 is never issued.
- Misaligned target:
  - Stimulus: jmp_target_i=0x46.
  - Response: pc_o=0x44 and misalign_o=1 for one cycle.
- Halt and resume:
  - Stimulus: halt_i at pc=0x20.
  - Response: fetch_valid_o=0 and pc_o=0x24 frozen; resume_i gives fetch_valid_o=1 and the sequence continues 0x28.
- Wrap and perf:
  - Stimulus: RESET_VEC=0xFFFF_FFFC.
  - Response: next pc_o=0x0.
  - With PC_PERF_EN defined: fetch_cnt_o=2 after 2 adv cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths/vectors, PC FSM states and redirect priorities.
package cpu_pkg;

   localparam int unsigned XLEN_DEF      = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_001C;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } pc_state_t;

   // Encoded so that a numerically larger value has higher priority.
   typedef enum logic [1:0] {
      SrcNone = 2'd0,
      SrcBr   = 2'd1,
      SrcJmp  = 2'd2,
      SrcTrap = 2'd3
   } redir_src_t;

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// Pending-redirect register: holds a redirect that arrived while fetch could not
// advance, and arbitrates it against a newly arriving redirect by priority.
module pc_redirect_buf
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  redir_src_t      new_src_i,
   input  logic [XLEN-1:0] new_tgt_i,
   input  logic            capture_i,  // store a winning new redirect
   input  logic            clear_i,    // pending consumed or superseded
   output redir_src_t      sel_src_o,
   output logic [XLEN-1:0] sel_tgt_o
);

   redir_src_t      pend_src_q, pend_src_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            new_wins;

   // Arbitrate new vs pending; ties go to the newer redirect.
   always_comb begin
      new_wins   = (new_src_i != SrcNone) &&
                   ((pend_src_q == SrcNone) || (new_src_i >= pend_src_q));
      sel_src_o  = new_wins ? new_src_i : pend_src_q;
      sel_tgt_o  = new_wins ? new_tgt_i : pend_tgt_q;
      pend_src_d = pend_src_q;
      pend_tgt_d = pend_tgt_q;
      if (clear_i) begin
         pend_src_d = SrcNone;
      end else if (capture_i && new_wins) begin
         pend_src_d = new_src_i;
         pend_tgt_d = new_tgt_i;
      end
   end

   // Pending register; an in-flight redirect is dropped on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_src_q <= SrcNone;
         pend_tgt_q <= '0;
      end else begin
         pend_src_q <= pend_src_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: issues the fetch PC with a valid/ready handshake,
// applies prioritised redirects (trap > jump > branch), buffers redirects that
// arrive while fetch is blocked, and supports halt/resume.
// Optional macro PC_PERF_EN adds saturating fetch/redirect counters.
module pc_gen
   import cpu_pkg::*;
#(
   parameter int unsigned     XLEN      = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DEF,
   parameter int unsigned     STEP      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            fetch_ready_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            jmp_i,
   input  logic [XLEN-1:0] jmp_target_i,
   input  logic            trap_i,
   input  logic            halt_i,
   input  logic            resume_i,
`ifdef PC_PERF_EN
   output logic [31:0]     fetch_cnt_o,
   output logic [31:0]     redirect_cnt_o,
`endif
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            fetch_valid_o,
   output logic            flush_o,
   output logic            misalign_o
);

   localparam logic [XLEN-1:0] LowMask  = XLEN'(STEP - 1);
   localparam logic [XLEN-1:0] StepInc  = XLEN'(STEP);

   pc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;

   logic            adv;
   redir_src_t      new_src;
   logic [XLEN-1:0] new_tgt;
   redir_src_t      sel_src;
   logic [XLEN-1:0] sel_tgt;
   logic            buf_capture;
   logic            buf_clear;

   // Fixed-priority select among the incoming redirect requests.
   always_comb begin
      new_src = SrcNone;
      new_tgt = br_target_i;
      if (trap_i) begin
         new_src = SrcTrap;
         new_tgt = TRAP_VEC;
      end else if (jmp_i) begin
         new_src = SrcJmp;
         new_tgt = jmp_target_i;
      end else if (br_taken_i) begin
         new_src = SrcBr;
         new_tgt = br_target_i;
      end
   end

   assign adv         = (state_q == StRun) && fetch_ready_i && !stall_i;
   assign buf_capture = (state_q != StHalt) && !adv;
   // A trap out of HALT supersedes any older buffered redirect.
   assign buf_clear   = adv || ((state_q == StHalt) && trap_i);

   pc_redirect_buf #(
      .XLEN (XLEN)
   ) u_redirect_buf (
      .clk       (clk),
      .rst       (rst),
      .new_src_i (new_src),
      .new_tgt_i (new_tgt),
      .capture_i (buf_capture),
      .clear_i   (buf_clear),
      .sel_src_o (sel_src),
      .sel_tgt_o (sel_tgt)
   );

   // Next-state, next-PC and pulse generation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush_d    = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (adv) begin
               if (sel_src != SrcNone) begin
                  pc_d       = sel_tgt & ~LowMask;
                  flush_d    = 1'b1;
                  misalign_d = |(sel_tgt & LowMask);
               end else begin
                  pc_d = pc_q + StepInc;
               end
            end
            if (halt_i) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            if (trap_i) begin
               state_d    = StRun;
               pc_d       = TRAP_VEC & ~LowMask;
               flush_d    = 1'b1;
               misalign_d = |(TRAP_VEC & LowMask);
            end else if (resume_i && !halt_i) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   // Architectural PC state and registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VEC;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o          = pc_q;
   assign pc_plus_o     = pc_q + StepInc;
   assign fetch_valid_o = (state_q == StRun);
   assign flush_o       = flush_q;
   assign misalign_o    = misalign_q;

`ifdef PC_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] redirect_cnt_q;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (adv && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (flush_q && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt_o    = fetch_cnt_q;
   assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed stimulus, expected outputs queued per
// cycle and compared after the clock edge. A second instance checks PC wrap.
module tb_pc_gen;
   import cpu_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic        flush;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, fetch_ready_i, br_taken_i, jmp_i, trap_i, halt_i, resume_i;
   logic [31:0] br_target_i, jmp_target_i;
   logic [31:0] pc_o, pc_plus_o, pc2_o, pc2_plus_o;
   logic        fetch_valid_o, flush_o, misalign_o;
   logic        valid2_o, flush2_o, mis2_o;
`ifdef PC_PERF_EN
   logic [31:0] fetch_cnt_o, redirect_cnt_o, fetch_cnt2_o, redirect_cnt2_o;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .fetch_ready_i (fetch_ready_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .jmp_i         (jmp_i),
      .jmp_target_i  (jmp_target_i),
      .trap_i        (trap_i),
      .halt_i        (halt_i),
      .resume_i      (resume_i),
`ifdef PC_PERF_EN
      .fetch_cnt_o   (fetch_cnt_o),
      .redirect_cnt_o(redirect_cnt_o),
`endif
      .pc_o          (pc_o),
      .pc_plus_o     (pc_plus_o),
      .fetch_valid_o (fetch_valid_o),
      .flush_o       (flush_o),
      .misalign_o    (misalign_o)
   );

   pc_gen #(
      .RESET_VEC (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .fetch_ready_i (fetch_ready_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .jmp_i         (jmp_i),
      .jmp_target_i  (jmp_target_i),
      .trap_i        (trap_i),
      .halt_i        (halt_i),
      .resume_i      (resume_i),
`ifdef PC_PERF_EN
      .fetch_cnt_o   (fetch_cnt2_o),
      .redirect_cnt_o(redirect_cnt2_o),
`endif
      .pc_o          (pc2_o),
      .pc_plus_o     (pc2_plus_o),
      .fetch_valid_o (valid2_o),
      .flush_o       (flush2_o),
      .misalign_o    (mis2_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      stall_i = 1'b0; fetch_ready_i = 1'b1; br_taken_i = 1'b0; jmp_i = 1'b0;
      trap_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
      br_target_i = '0; jmp_target_i = '0;
   endtask

   // Push the expectation for the inputs now driven, clock once, pop and compare.
   task automatic tick(input string tag, input logic [31:0] pc, input logic v,
                       input logic f, input logic m);
      exp_t e;
      sb_q.push_back('{pc: pc, valid: v, flush: f, mis: m});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, ".pc"}, pc_o, e.pc);
      check({tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, e.valid});
      check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, e.flush});
      check({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, e.mis});
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.pc", pc_o, 32'h0);
      check("rst.valid", {31'd0, fetch_valid_o}, 32'd0);
      check("rst.flush", {31'd0, flush_o}, 32'd0);
      check("rst.mis", {31'd0, misalign_o}, 32'd0);
      check("rst.wrap_pc", pc2_o, 32'hFFFF_FFFC);
      rst = 1'b0;
      #1;
      check("boot.valid", {31'd0, fetch_valid_o}, 32'd0);
      check("boot.pc_plus", pc_plus_o, 32'h4);

      // Sequential fetch.
      tick("seq0", 32'h0, 1'b1, 1'b0, 1'b0);
      check("wrap.first", pc2_o, 32'hFFFF_FFFC);
      tick("seq1", 32'h4, 1'b1, 1'b0, 1'b0);
      check("wrap.next", pc2_o, 32'h0);
      tick("seq2", 32'h8, 1'b1, 1'b0, 1'b0);
      tick("seq3", 32'hC, 1'b1, 1'b0, 1'b0);
      tick("seq4", 32'h10, 1'b1, 1'b0, 1'b0);

      // Branch and jump together: jump wins.
      br_taken_i = 1'b1; br_target_i = 32'h40; jmp_i = 1'b1; jmp_target_i = 32'h80;
      tick("brjmp", 32'h80, 1'b1, 1'b1, 1'b0);
      tick("brjmp.after", 32'h84, 1'b1, 1'b0, 1'b0);

      // Buffered redirect: branch then trap while stalled; trap applies after release.
      stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h100;
      tick("buf.s1", 32'h84, 1'b1, 1'b0, 1'b0);
      stall_i = 1'b1; trap_i = 1'b1;
      tick("buf.s2", 32'h84, 1'b1, 1'b0, 1'b0);
      stall_i = 1'b1;
      tick("buf.s3", 32'h84, 1'b1, 1'b0, 1'b0);
      tick("buf.rel", 32'h1C, 1'b1, 1'b1, 1'b0);
      tick("buf.after", 32'h20, 1'b1, 1'b0, 1'b0);

      // Halt at 0x20, halt+resume (halt wins), then resume.
      halt_i = 1'b1;
      tick("halt", 32'h24, 1'b0, 1'b0, 1'b0);
      tick("halt.frozen", 32'h24, 1'b0, 1'b0, 1'b0);
      halt_i = 1'b1; resume_i = 1'b1;
      tick("halt.both", 32'h24, 1'b0, 1'b0, 1'b0);
      resume_i = 1'b1;
      tick("resume", 32'h24, 1'b1, 1'b0, 1'b0);
      tick("resume.next", 32'h28, 1'b1, 1'b0, 1'b0);

      // Misaligned jump target.
      jmp_i = 1'b1; jmp_target_i = 32'h46;
      tick("misalign", 32'h44, 1'b1, 1'b1, 1'b1);
      tick("misalign.after", 32'h48, 1'b1, 1'b0, 1'b0);

      // Pending trap beats a lower-priority jump arriving on release.
      stall_i = 1'b1; trap_i = 1'b1;
      tick("pend.trap", 32'h48, 1'b1, 1'b0, 1'b0);
      jmp_i = 1'b1; jmp_target_i = 32'h200;
      tick("pend.keep", 32'h1C, 1'b1, 1'b1, 1'b0);
      tick("pend.keep2", 32'h20, 1'b1, 1'b0, 1'b0);

      // Higher-priority jump on release beats a pending branch.
      stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h300;
      tick("pend.br", 32'h20, 1'b1, 1'b0, 1'b0);
      jmp_i = 1'b1; jmp_target_i = 32'h400;
      tick("pend.new", 32'h400, 1'b1, 1'b1, 1'b0);
      tick("pend.new2", 32'h404, 1'b1, 1'b0, 1'b0);

      // Not ready: hold.
      fetch_ready_i = 1'b0;
      tick("notready", 32'h404, 1'b1, 1'b0, 1'b0);
      tick("ready", 32'h408, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset takes effect before the next edge.
      rst = 1'b1;
      #2;
      check("arst.pc", pc_o, 32'h0);
      check("arst.valid", {31'd0, fetch_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Redirect during BOOT is buffered, then applied on the first advance.
      br_taken_i = 1'b1; br_target_i = 32'h60;
      tick("boot.br", 32'h0, 1'b1, 1'b0, 1'b0);
      tick("boot.apply", 32'h60, 1'b1, 1'b1, 1'b0);
      tick("boot.after", 32'h64, 1'b1, 1'b0, 1'b0);
`ifdef PC_PERF_EN
      check("perf.fetch", fetch_cnt_o, 32'd2);
      check("perf.redirect", redirect_cnt_o, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
